// File: rtl/kypd_pkg.sv
// Shared types, keymap and frame decoder for the hex keypad scanner.
package kypd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } kypd_state_t;

  // A valid result means exactly one key is down. Multi means two or more.
  // Neither bit set means no key is down.
  typedef struct packed {
    logic       valid;
    logic       multi;
    logic [3:0] code;
  } kypd_result_t;

  // KEYMAP[row][col] holds the hex code printed on that key.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Reduce a full frame of key bits (bit row*4+col set = pressed) to a result.
  function automatic kypd_result_t decode_frame(input logic [15:0] keys);
    kypd_result_t r;
    int           n;
    r = '0;
    n = 0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        if (keys[row*4+col]) begin
          n++;
          r.code = KEYMAP[row][col];
        end
      end
    end
    r.valid = (n == 1);
    r.multi = (n > 1);
    if (n != 1) r.code = '0;
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = {W{1'b1}}
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Resample the input twice before it is used anywhere downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_hex_scanner.sv
// 4x4 hex keypad scanner: one-cold column drive, per-frame decode, press and
// release debounce, one key_valid pulse per press, and a digit shift register.
//
// state    | meaning
// IDLE     | no key accepted; waiting for a single-key frame
// PRESS_DB | same key seen in cnt consecutive frames, not yet accepted
// HELD     | key accepted; ignoring everything until the keypad goes quiet
// REL_DB   | empty frames seen cnt times in a row after a held key
module keypad_hex_scanner
  import kypd_pkg::*;
#(
  parameter int N        = 16,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   rows,
  input  logic         clear,
  output logic [3:0]   cols,
  output logic         key_valid,
  output logic [3:0]   key_code,
  output logic [N-1:0] value
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [3:0]    rows_s;
  logic [DW-1:0] div;
  logic [1:0]    col;
  logic [15:0]   keys;
  logic [15:0]   keys_now;
  logic          slot_end;
  logic          frame_end;
  kypd_result_t  result;

  kypd_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    cand, cand_n;
  logic          accept;
  logic [N+3:0]  shifted;

  sync_2ff #(.W(4), .RST_VAL(4'b1111)) u_rows_sync (
    .clock (clock),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  assign slot_end  = (div == DW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (col == 2'd3);
  assign cols      = ~(4'b0001 << col);
  assign shifted   = {value, cand_n};

  // Merge the current column's rows into the stored frame so the column-3
  // sample can be decoded in the same cycle it is taken.
  always_comb begin
    keys_now = keys;
    for (int r = 0; r < 4; r++) begin
      keys_now[r*4 + int'(col)] = ~rows_s[r];
    end
    result = decode_frame(keys_now);
  end

  // Slot divider, column pointer and per-column key capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div  <= '0;
      col  <= 2'd0;
      keys <= '0;
    end else if (slot_end) begin
      div  <= '0;
      col  <= col + 2'd1;
      keys <= keys_now;
    end else begin
      div  <= div + DW'(1);
    end
  end

  // Debounce state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 4'h0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  // Next-state logic, evaluated only on frame ends.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (result.valid) begin
            cand_n = result.code;
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_n = HELD;
              cnt_n   = '0;
            end else begin
              state_n = PRESS_DB;
              cnt_n   = CW'(1);
            end
          end
        end
        PRESS_DB: begin
          if (result.valid && (result.code == cand)) begin
            if (cnt + CW'(1) == CW'(DEBOUNCE)) begin
              accept  = 1'b1;
              state_n = HELD;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        HELD: begin
          if (!result.valid && !result.multi) begin
            if (DEBOUNCE == 1) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              state_n = REL_DB;
              cnt_n   = CW'(1);
            end
          end
        end
        REL_DB: begin
          if (!result.valid && !result.multi) begin
            if (cnt + CW'(1) == CW'(DEBOUNCE)) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else begin
            state_n = HELD;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Registered outputs; clear overrides the digit shift but not the pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      value     <= '0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= cand_n;
      if (clear) value <= '0;
      else if (accept) value <= shifted[N-1:0];
    end
  end

endmodule

// File: tb/tb_keypad_hex_scanner.sv
// Directed bench for keypad_hex_scanner with SCAN_DIV=4, DEBOUNCE=2, N=16.
module tb_keypad_hex_scanner;

  logic        clock;
  logic        reset;
  logic [3:0]  rows;
  logic        clear;
  logic [3:0]  cols;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] value;

  logic [15:0] pressed;
  int          checks;
  int          failures;
  int          pulses;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulses;
    logic [3:0]  code;
    logic [15:0] value;
  } vec_t;

  vec_t vecs [24];

  keypad_hex_scanner #(.N(16), .SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .rows      (rows),
    .clear     (clear),
    .cols      (cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .value     (value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (key_valid === 1'b1) pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    int          p0;
    logic [3:0]  ecols;
    checks   = 0;
    failures = 0;
    pulses   = 0;
    pressed  = '0;
    clear    = 1'b0;
    reset    = 1'b1;

    // key bit = row*4+col: 5=b5 1=b0 A=b3 3=b2 F=b13 7=b8 9=b10 2=b1 8=b9 C=b11
    vecs[0]  = '{16'h0000, 2, 0, 4'h0, 16'h0000};
    vecs[1]  = '{16'h0020, 3, 1, 4'h5, 16'h0005};
    vecs[2]  = '{16'h0000, 3, 0, 4'h5, 16'h0005};
    vecs[3]  = '{16'h0001, 3, 1, 4'h1, 16'h0051};
    vecs[4]  = '{16'h0000, 3, 0, 4'h1, 16'h0051};
    vecs[5]  = '{16'h0008, 3, 1, 4'hA, 16'h051A};
    vecs[6]  = '{16'h0000, 3, 0, 4'hA, 16'h051A};
    vecs[7]  = '{16'h0004, 3, 1, 4'h3, 16'h51A3};
    vecs[8]  = '{16'h0000, 3, 0, 4'h3, 16'h51A3};
    vecs[9]  = '{16'h2000, 3, 1, 4'hF, 16'h1A3F};
    vecs[10] = '{16'h0000, 3, 0, 4'hF, 16'h1A3F};
    vecs[11] = '{16'h0100, 3, 1, 4'h7, 16'hA3F7};
    vecs[12] = '{16'h0000, 3, 0, 4'h7, 16'hA3F7};
    vecs[13] = '{16'h0400, 1, 0, 4'h7, 16'hA3F7};
    vecs[14] = '{16'h0000, 3, 0, 4'h7, 16'hA3F7};
    vecs[15] = '{16'h0002, 3, 1, 4'h2, 16'h3F72};
    vecs[16] = '{16'h0202, 3, 0, 4'h2, 16'h3F72};
    vecs[17] = '{16'h0000, 3, 0, 4'h2, 16'h3F72};
    vecs[18] = '{16'h0200, 3, 1, 4'h8, 16'hF728};
    vecs[19] = '{16'h0000, 3, 0, 4'h8, 16'hF728};
    vecs[20] = '{16'h0202, 3, 0, 4'h8, 16'hF728};
    vecs[21] = '{16'h0000, 3, 0, 4'h8, 16'hF728};
    vecs[22] = '{16'h0020, 6, 1, 4'h5, 16'h7285};
    vecs[23] = '{16'h0000, 3, 0, 4'h5, 16'h7285};

    @(negedge clock);
    @(negedge clock);
    check("rst_cols", cols, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 4'h0);
    check("rst_value", value, 16'h0000);
    reset = 1'b0;

    // Column rotation: after k clocks the driven column is (k/4)%4.
    for (int k = 1; k <= 16; k++) begin
      tick();
      ecols = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("cols_k%0d", k), cols, ecols);
    end

    // Step boundaries sit two clocks into a frame so each step's last
    // frame-end pulse lands inside that same step.
    tick();
    tick();

    for (int i = 0; i < 24; i++) begin
      p0 = pulses;
      pressed = vecs[i].keys;
      repeat (vecs[i].frames * 16) tick();
      check($sformatf("v%0d_pulses", i), pulses - p0, vecs[i].pulses);
      check($sformatf("v%0d_code", i), key_code, vecs[i].code);
      check($sformatf("v%0d_value", i), value, vecs[i].value);
    end

    // clear coincident with the accept of C.
    p0 = pulses;
    pressed = 16'h0800;
    repeat (29) tick();
    check("clr_pre_value", value, 16'h7285);
    check("clr_pre_valid", key_valid, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_valid", key_valid, 1'b1);
    check("clr_code", key_code, 4'hC);
    check("clr_value", value, 16'h0000);
    tick();
    check("clr_pulse_width", key_valid, 1'b0);
    repeat (17) tick();
    pressed = '0;
    repeat (48) tick();
    check("clr_pulses", pulses - p0, 1);
    check("clr_post_value", value, 16'h0000);

    // Reset in the middle of a press debounce.
    p0 = pulses;
    pressed = 16'h0020;
    repeat (20) tick();
    check("mid_cols_pre", cols, 4'b1101);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cols", cols, 4'b1110);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_value", value, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    p0 = pulses;
    repeat (29) tick();
    check("mid_no_early_pulse", pulses - p0, 0);
    repeat (2) tick();
    check("mid_redebounce_pulse", pulses - p0, 1);
    check("mid_code", key_code, 4'h5);
    check("mid_value", value, 16'h0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
